// File: rtl/mem_arb_pkg.sv
// ============================================================================
// Module  : mem_arb_pkg
// Brief   : Shared types and constants for the memory port arbiter.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package mem_arb_pkg;

  typedef enum logic {
    IDLE    = 1'b0,
    RD_WAIT = 1'b1
  } state_e;

  typedef enum logic {
    OWN_CPU = 1'b0,
    OWN_DBG = 1'b1
  } owner_e;

  localparam int WAIT_W = 4;
  // Wide enough for a MEM_LAT-1 countdown with MEM_LAT up to 4.
  localparam int LAT_W  = 2;

endpackage

`default_nettype wire

// File: rtl/arb_wait_ctr.sv
// ============================================================================
// Module  : arb_wait_ctr
// Brief   : Saturating starvation counter; flags when the deferral limit is hit.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module arb_wait_ctr
  import mem_arb_pkg::*;
#(
  parameter int MAX_WAIT = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic inc,
  input  logic clr,
  output logic ge_max
);

  localparam logic [WAIT_W-1:0] MAX_CNT = WAIT_W'(MAX_WAIT);
  localparam logic [WAIT_W-1:0] SAT_CNT = '1;

  logic [WAIT_W-1:0] cnt_q;
  logic [WAIT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != SAT_CNT)) begin
      cnt_d = cnt_q + WAIT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign ge_max = (cnt_q >= MAX_CNT);

endmodule

`default_nettype wire

// File: rtl/mem_port_arbiter.sv
// ============================================================================
// Module  : mem_port_arbiter
// Brief   : Shares one memory port between CPU and debug requesters.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int MEM_LAT  = 1,
  parameter int MAX_WAIT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  output logic              dbg_gnt,
  output logic              dbg_rvalid,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  localparam logic [LAT_W-1:0] LAT_INIT = LAT_W'(MEM_LAT - 1);

  state_e             state_q, state_d;
  owner_e             owner_q, owner_d;
  logic [LAT_W-1:0]   lat_q, lat_d;
  logic [DATA_W-1:0]  cpu_rdata_q, cpu_rdata_d;
  logic [DATA_W-1:0]  dbg_rdata_q, dbg_rdata_d;
  logic               dbg_force;

  arb_wait_ctr #(
    .MAX_WAIT (MAX_WAIT)
  ) u_wait_ctr (
    .clk    (clk),
    .reset  (reset),
    .inc    (dbg_req & ~dbg_gnt),
    .clr    (dbg_gnt | ~dbg_req),
    .ge_max (dbg_force)
  );

  // Grants and rvalid are combinational, so they are gated by reset to keep
  // every output quiet while reset is held.
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    lat_d       = lat_q;
    cpu_rdata_d = cpu_rdata_q;
    dbg_rdata_d = dbg_rdata_q;
    cpu_gnt     = 1'b0;
    dbg_gnt     = 1'b0;
    cpu_rvalid  = 1'b0;
    dbg_rvalid  = 1'b0;
    cpu_rdata   = cpu_rdata_q;
    dbg_rdata   = dbg_rdata_q;
    mem_en      = 1'b0;
    mem_we      = 1'b0;
    mem_addr    = '0;
    mem_wdata   = '0;

    unique case (state_q)
      IDLE: begin
        if (reset) begin
          if (dbg_req && dbg_force) begin
            dbg_gnt = 1'b1;
          end else if (cpu_req) begin
            cpu_gnt = 1'b1;
          end else if (dbg_req) begin
            dbg_gnt = 1'b1;
          end
        end

        if (cpu_gnt) begin
          mem_en    = 1'b1;
          mem_we    = cpu_we;
          mem_addr  = cpu_addr;
          mem_wdata = cpu_wdata;
          if (!cpu_we) begin
            state_d = RD_WAIT;
            owner_d = OWN_CPU;
            lat_d   = LAT_INIT;
          end
        end else if (dbg_gnt) begin
          mem_en    = 1'b1;
          mem_we    = dbg_we;
          mem_addr  = dbg_addr;
          mem_wdata = dbg_wdata;
          if (!dbg_we) begin
            state_d = RD_WAIT;
            owner_d = OWN_DBG;
            lat_d   = LAT_INIT;
          end
        end
      end

      RD_WAIT: begin
        if (lat_q == '0) begin
          state_d = IDLE;
          if (reset) begin
            if (owner_q == OWN_CPU) begin
              cpu_rvalid  = 1'b1;
              cpu_rdata   = mem_rdata;
              cpu_rdata_d = mem_rdata;
            end else begin
              dbg_rvalid  = 1'b1;
              dbg_rdata   = mem_rdata;
              dbg_rdata_d = mem_rdata;
            end
          end
        end else begin
          lat_d = lat_q - LAT_W'(1);
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      owner_q     <= OWN_CPU;
      lat_q       <= '0;
      cpu_rdata_q <= '0;
      dbg_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      lat_q       <= lat_d;
      cpu_rdata_q <= cpu_rdata_d;
      dbg_rdata_q <= dbg_rdata_d;
    end
  end

  assign busy = (state_q == RD_WAIT);

endmodule

`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
// ============================================================================
// Module  : tb_mem_port_arbiter
// Brief   : Self-checking bench; one DUT with MEM_LAT=1 and one with MEM_LAT=3.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_mem_port_arbiter;

  logic        clk;
  logic        reset;
  logic        cpu_req, cpu_we, dbg_req, dbg_we;
  logic [31:0] cpu_addr, cpu_wdata, dbg_addr, dbg_wdata;

  // DUT "a": MEM_LAT=1
  logic        a_cpu_gnt, a_cpu_rvalid, a_dbg_gnt, a_dbg_rvalid;
  logic        a_mem_en, a_mem_we, a_busy;
  logic [31:0] a_cpu_rdata, a_dbg_rdata, a_mem_addr, a_mem_wdata, a_mem_rdata;
  // DUT "b": MEM_LAT=3
  logic        b_cpu_gnt, b_cpu_rvalid, b_dbg_gnt, b_dbg_rvalid;
  logic        b_mem_en, b_mem_we, b_busy;
  logic [31:0] b_cpu_rdata, b_dbg_rdata, b_mem_addr, b_mem_wdata, b_mem_rdata;

  int          total = 0;
  int          bad   = 0;
  int          sb_sel;
  logic [31:0] q_cpu[$];
  logic [31:0] q_dbg[$];

  int          a_age, b_age;
  logic [31:0] a_rd_addr, b_rd_addr;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1), .MAX_WAIT(4)) u_dut_a (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(a_cpu_gnt), .cpu_rvalid(a_cpu_rvalid), .cpu_rdata(a_cpu_rdata),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_gnt(a_dbg_gnt), .dbg_rvalid(a_dbg_rvalid), .dbg_rdata(a_dbg_rdata),
    .mem_en(a_mem_en), .mem_we(a_mem_we), .mem_addr(a_mem_addr), .mem_wdata(a_mem_wdata),
    .mem_rdata(a_mem_rdata), .busy(a_busy)
  );

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(3), .MAX_WAIT(4)) u_dut_b (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(b_cpu_gnt), .cpu_rvalid(b_cpu_rvalid), .cpu_rdata(b_cpu_rdata),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_gnt(b_dbg_gnt), .dbg_rvalid(b_dbg_rvalid), .dbg_rdata(b_dbg_rdata),
    .mem_en(b_mem_en), .mem_we(b_mem_we), .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata),
    .mem_rdata(b_mem_rdata), .busy(b_busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] mem_val(input logic [31:0] addr);
    if (addr == 32'h10) return 32'hDEAD_BEEF;
    return {addr[15:0], 16'h5A5A};
  endfunction

  // Memory models: data is valid only in the exact cycle issue+latency.
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      a_age <= 0;
      b_age <= 0;
    end else begin
      if (a_mem_en && !a_mem_we) begin
        a_rd_addr <= a_mem_addr;
        a_age     <= 1;
      end else if (a_age != 0 && a_age < 15) begin
        a_age <= a_age + 1;
      end
      if (b_mem_en && !b_mem_we) begin
        b_rd_addr <= b_mem_addr;
        b_age     <= 1;
      end else if (b_age != 0 && b_age < 15) begin
        b_age <= b_age + 1;
      end
    end
  end

  assign a_mem_rdata = (a_age == 1) ? mem_val(a_rd_addr) : 32'hBAD0_BAD0;
  assign b_mem_rdata = (b_age == 3) ? mem_val(b_rd_addr) : 32'hBAD0_BAD0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Read-data scoreboard for the DUT selected by sb_sel.
  always begin
    logic        rv_c, rv_d;
    logic [31:0] rd_c, rd_d;
    @(negedge clk);
    #2;
    rv_c = (sb_sel == 1) ? a_cpu_rvalid : b_cpu_rvalid;
    rv_d = (sb_sel == 1) ? a_dbg_rvalid : b_dbg_rvalid;
    rd_c = (sb_sel == 1) ? a_cpu_rdata  : b_cpu_rdata;
    rd_d = (sb_sel == 1) ? a_dbg_rdata  : b_dbg_rdata;
    if (rv_c) begin
      if (q_cpu.size() == 0) chk("sb_cpu_unexpected_rvalid", 32'd1, 32'd0);
      else chk("sb_cpu_rdata", rd_c, q_cpu.pop_front());
    end
    if (rv_d) begin
      if (q_dbg.size() == 0) chk("sb_dbg_unexpected_rvalid", 32'd1, 32'd0);
      else chk("sb_dbg_rdata", rd_d, q_dbg.pop_front());
    end
  end

  initial begin
    sb_sel    = 1;
    reset     = 1'b0;
    cpu_req   = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h100; cpu_wdata = 32'h11;
    dbg_req   = 1'b0; dbg_we = 1'b0; dbg_addr = 32'h0;   dbg_wdata = 32'h0;

    // Test 1: reset held with a pending request.
    repeat (3) @(negedge clk);
    #1;
    chk("t1_rst_cpu_gnt", a_cpu_gnt, 0);
    chk("t1_rst_mem_en",  a_mem_en,  0);
    chk("t1_rst_mem_we",  a_mem_we,  0);
    chk("t1_rst_mem_addr", a_mem_addr, 0);
    chk("t1_rst_busy",    a_busy,    0);
    chk("t1_rst_cpu_rdata", a_cpu_rdata, 0);
    chk("t1_rst_dbg_rdata", a_dbg_rdata, 0);
    chk("t1_rst_b_gnt",   b_cpu_gnt, 0);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("t1_first_cpu_gnt", a_cpu_gnt, 1);
    chk("t1_first_mem_en",  a_mem_en,  1);
    chk("t1_first_mem_addr", a_mem_addr, 32'h100);
    chk("t1_first_b_gnt",   b_cpu_gnt, 1);
    @(negedge clk);
    cpu_req = 1'b0;
    repeat (2) @(negedge clk);

    // Test 2: CPU read, MEM_LAT=1.
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h10;
    q_cpu.push_back(mem_val(32'h10));
    #1;
    chk("t2_cpu_gnt",   a_cpu_gnt, 1);
    chk("t2_mem_addr",  a_mem_addr, 32'h10);
    chk("t2_mem_we",    a_mem_we, 0);
    chk("t2_busy_g",    a_busy, 0);
    @(negedge clk);
    cpu_req = 1'b0;
    #1;
    chk("t2_cpu_rvalid", a_cpu_rvalid, 1);
    chk("t2_cpu_rdata",  a_cpu_rdata, 32'hDEAD_BEEF);
    chk("t2_dbg_rvalid", a_dbg_rvalid, 0);
    chk("t2_busy",       a_busy, 1);
    repeat (4) @(negedge clk);
    #1;
    chk("t2_rdata_hold",  a_cpu_rdata, 32'hDEAD_BEEF);
    chk("t2_rvalid_gone", a_cpu_rvalid, 0);
    chk("t2_dbg_rdata",   a_dbg_rdata, 0);

    // Test 3: simultaneous writes, starvation forces debug on the 5th cycle.
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h200; cpu_wdata = 32'hC0;
    dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 32'h300; dbg_wdata = 32'hD0;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk($sformatf("t3_cpu_gnt_%0d", i), a_cpu_gnt, 1);
      chk($sformatf("t3_dbg_gnt_%0d", i), a_dbg_gnt, 0);
      @(negedge clk);
    end
    #1;
    chk("t3_dbg_forced",  a_dbg_gnt, 1);
    chk("t3_cpu_held",    a_cpu_gnt, 0);
    chk("t3_mem_we",      a_mem_we, 1);
    chk("t3_mem_addr",    a_mem_addr, 32'h300);
    chk("t3_mem_wdata",   a_mem_wdata, 32'hD0);
    @(negedge clk);
    dbg_req = 1'b0;
    #1;
    chk("t3_cpu_resume",  a_cpu_gnt, 1);
    @(negedge clk);
    cpu_req = 1'b0;
    repeat (3) @(negedge clk);

    // Test 4: debug read with MEM_LAT=3 blocks the CPU.
    sb_sel  = 3;
    dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 32'h40;
    q_dbg.push_back(mem_val(32'h40));
    #1;
    chk("t4_dbg_gnt", b_dbg_gnt, 1);
    @(negedge clk);
    dbg_req = 1'b0;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h500; cpu_wdata = 32'h55;
    for (int k = 1; k <= 3; k++) begin
      #1;
      chk($sformatf("t4_no_cpu_gnt_%0d", k), b_cpu_gnt, 0);
      chk($sformatf("t4_busy_%0d", k), b_busy, 1);
      if (k == 3) begin
        chk("t4_dbg_rvalid", b_dbg_rvalid, 1);
        chk("t4_dbg_rdata",  b_dbg_rdata, mem_val(32'h40));
      end else begin
        chk($sformatf("t4_dbg_rvalid_early_%0d", k), b_dbg_rvalid, 0);
      end
      @(negedge clk);
    end
    #1;
    chk("t4_cpu_gnt_after", b_cpu_gnt, 1);
    @(negedge clk);
    cpu_req = 1'b0;
    repeat (3) @(negedge clk);

    // Test 5: reset pulse during an in-flight MEM_LAT=3 read.
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h80;
    q_cpu.push_back(mem_val(32'h80));
    #1;
    chk("t5_cpu_gnt", b_cpu_gnt, 1);
    chk("t5_rdata_before", b_cpu_rdata, 32'hDEAD_BEEF);
    @(negedge clk);
    cpu_req = 1'b0;
    #1;
    chk("t5_busy_before", b_busy, 1);
    #2;
    reset = 1'b0;
    q_cpu.delete();
    q_dbg.delete();
    #1;
    chk("t5_busy_reset",   b_busy, 0);
    chk("t5_rdata_reset",  b_cpu_rdata, 0);
    chk("t5_rvalid_reset", b_cpu_rvalid, 0);
    @(negedge clk);
    reset = 1'b1;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk($sformatf("t5_no_rvalid_%0d", k), b_cpu_rvalid, 0);
      @(negedge clk);
    end
    #1;
    chk("t5_rdata_after", b_cpu_rdata, 0);

    // Test 6: a dropped debug request restarts the starvation count.
    sb_sel  = 1;
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h600; cpu_wdata = 32'h66;
    dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 32'h700; dbg_wdata = 32'h77;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk($sformatf("t6_pre_dbg_gnt_%0d", k), a_dbg_gnt, 0);
      @(negedge clk);
    end
    dbg_req = 1'b0;
    #1;
    chk("t6_drop_dbg_gnt", a_dbg_gnt, 0);
    @(negedge clk);
    dbg_req = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk($sformatf("t6_defer_dbg_gnt_%0d", k), a_dbg_gnt, 0);
      chk($sformatf("t6_defer_cpu_gnt_%0d", k), a_cpu_gnt, 1);
      @(negedge clk);
    end
    #1;
    chk("t6_dbg_gnt", a_dbg_gnt, 1);
    chk("t6_dbg_addr", a_mem_addr, 32'h700);
    @(negedge clk);
    cpu_req = 1'b0;
    dbg_req = 1'b0;
    repeat (3) @(negedge clk);

    chk("end_q_cpu_empty", q_cpu.size(), 0);
    chk("end_q_dbg_empty", q_dbg.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single unified instruction/data memory port between two requesters: the multicycle CPU datapath (fetch, LDR and STR accesses) and the debug/loader port that writes programs and peeks memory.
- At most one transaction is outstanding at a time.
- Reads complete a fixed MEM_LAT cycles after issue.
- The CPU has default priority. A starvation counter guarantees that debug access is eventually served.

Parameters:
- ADDR_W, 32: address width.
- DATA_W, 32: data width.
- MEM_LAT, 1: memory read latency in cycles, legal range 1..4.
- MAX_WAIT, 4: cycles a pending debug request may be deferred before it is forced to win arbitration, legal range 1..15.

Ports:
- clk, in, 1: single clock, rising edge.
- reset, in, 1: asynchronous, active-low reset.
- cpu_req, in, 1: CPU request. Held with its fields stable until cpu_gnt.
- cpu_we, in, 1: 1 = write, 0 = read.
- cpu_addr, in, ADDR_W: CPU address.
- cpu_wdata, in, DATA_W: CPU write data.
- cpu_gnt, out, 1: one-cycle pulse; the CPU request is issued this cycle.
- cpu_rvalid, out, 1: one-cycle pulse; CPU read data valid.
- cpu_rdata, out, DATA_W: CPU read data.
- dbg_req, dbg_we, dbg_addr, dbg_wdata, dbg_gnt, dbg_rvalid, dbg_rdata: identical set for the debug port.
- mem_en, out, 1: memory access strobe.
- mem_we, out, 1: memory write enable.
- mem_addr, out, ADDR_W: memory address.
- mem_wdata, out, DATA_W: memory write data.
- mem_rdata, in, DATA_W: memory read data, valid MEM_LAT cycles after the mem_en cycle.
- busy, out, 1: high while a read is in flight.

Behaviour:
- Reset values:
  - All gnt, rvalid, mem_en, mem_we and busy outputs are 0.
  - cpu_rdata and dbg_rdata are 0.
  - The wait counter is 0 and the state is IDLE.
- States:
  - IDLE: arbitrate and issue.
  - RD_WAIT: a read is in flight; a latency counter runs from MEM_LAT-1 down to 0.
- Arbitration in IDLE, combinational in the same cycle:
  - Debug wins if dbg_req=1 and wait_cnt >= MAX_WAIT.
  - Otherwise the CPU wins if cpu_req=1.
  - Otherwise debug wins if dbg_req=1.
- Issue cycle G:
  - The winner's gnt=1.
  - mem_en=1; mem_we, mem_addr and mem_wdata are taken from the winner.
  - The loser's gnt=0.
  - Outside an issue cycle, mem_en=0, mem_we=0, and mem_addr/mem_wdata are 0.
- Write completes at G. The state stays IDLE, so a new grant is possible at G+1 and back-to-back writes run at one per cycle.
- Read:
  - Next state is RD_WAIT, recording the owner.
  - In cycle G+MEM_LAT the owner's rvalid=1 and its rdata = mem_rdata (combinational pass-through).
  - At the end of that cycle mem_rdata is captured into the owner's rdata hold register, and rdata holds that value until the owner's next read completes.
  - The non-owner's rvalid=0 and its rdata is unchanged.
  - The state returns to IDLE at G+MEM_LAT+1; the earliest next grant is G+MEM_LAT+1.
- No grants are issued in RD_WAIT. Requests simply wait.
- busy = (state == RD_WAIT).
- Wait counter (4 bits, saturating at 15):
  - Increments each cycle that dbg_req=1 and dbg_gnt=0.
  - Clears on dbg_gnt.
  - Clears when dbg_req=0.
- Request withdrawn before grant: allowed. No grant, no memory access.
- Simultaneous requests with wait_cnt < MAX_WAIT: the CPU is granted.
- Reset asserted mid-read: the in-flight read is discarded, no rvalid is issued, and all state returns to reset values immediately (asynchronously).

Decomposition:
- Package mem_arb_pkg holds:
  - the state enum {IDLE, RD_WAIT};
  - the owner enum {OWN_CPU, OWN_DBG};
  - the wait-counter width constant WAIT_W=4.
- One sub-module is natural: arb_wait_ctr, the saturating starvation counter with inc/clr inputs and a ge_max output.

Test Plan:
1. Hold reset=0 with cpu_req=1 → all outputs 0, no gnt. Release reset → cpu_gnt and mem_en=1 in the first active cycle.
2. MEM_LAT=1: CPU read addr 0x10, memory returns 0xDEADBEEF at G+1 → cpu_gnt at G with mem_addr=0x10 and mem_we=0; cpu_rvalid=1 at G+1 with cpu_rdata=0xDEADBEEF; dbg_rvalid=0; busy=1 during G+1; cpu_rdata still 0xDEADBEEF at G+5.
3. cpu_req and dbg_req raised together, both writes, with cpu_req held high continuously for back-to-back writes → cpu_gnt on the first 4 cycles; dbg_gnt forced on the 5th cycle with mem_we=1 and dbg_addr on mem_addr; the CPU resumes the following cycle.
4. MEM_LAT=3: debug read addr 0x40 while the CPU requests at G+1 → no cpu_gnt during G+1..G+3; dbg_rvalid at G+3; cpu_gnt at G+4.
5. reset pulsed low at G+1 of a MEM_LAT=3 CPU read → busy=0 immediately, no cpu_rvalid ever, cpu_rdata=0.
6. dbg_req high for 3 cycles under CPU traffic, dropped for 1 cycle, then re-raised → no dbg_gnt; the counter restarts from 0, so dbg_gnt arrives only after 4 more deferred cycles.
